// File: rtl/xgmii_pkg.sv
// Shared XGMII byte/word constants and the TX arbiter state encoding.
package xgmii_pkg;

    localparam logic [7:0]  XGMII_IDLE       = 8'h07;
    localparam logic [7:0]  XGMII_ERROR      = 8'hFE;
    localparam logic [7:0]  XGMII_CTRL_ALL   = 8'hFF;
    localparam logic [63:0] XGMII_IDLE_WORD  = {8{XGMII_IDLE}};
    localparam logic [63:0] XGMII_ERROR_WORD = {8{XGMII_ERROR}};

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StIfg
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned NPORT = 4
) (
    input  logic [NPORT-1:0]         req,
    input  logic [$clog2(NPORT)-1:0] last,
    output logic                     found,
    output logic [$clog2(NPORT)-1:0] idx
);

    localparam int unsigned PW = $clog2(NPORT);

    logic [PW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int unsigned k = 0; k < NPORT; k++) begin
            cand = (cand == PW'(NPORT - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_arb.sv
// Round-robin arbiter sharing one XGMII TX lane between NPORT frame sources,
// with inter-frame gap insertion and forced abort of over-long grants.
module xgmii_tx_arb
    import xgmii_pkg::*;
#(
    parameter int unsigned NPORT     = 4,
    parameter int unsigned IFG_WORDS = 1,
    parameter int unsigned MAX_WORDS = 1200
) (
    input  logic                     xgmii_clk,
    input  logic                     sys_rst,
    input  logic [NPORT-1:0]         req,
    output logic [NPORT-1:0]         gnt,
    input  logic [64*NPORT-1:0]      src_txd,
    input  logic [8*NPORT-1:0]       src_txc,
    input  logic [NPORT-1:0]         src_eof,
    output logic [63:0]              xgmii_txd,
    output logic [7:0]               xgmii_txc,
    output logic                     busy,
    output logic [$clog2(NPORT)-1:0] cur_port,
    output logic [15:0]              abort_cnt
);

    localparam int unsigned PW  = $clog2(NPORT);
    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);
    localparam int unsigned ICW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

    arb_state_e       state_q, state_d;
    logic [NPORT-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    cur_port_q, cur_port_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [ICW-1:0]   ifg_cnt_q, ifg_cnt_d;
    logic [15:0]      abort_cnt_q, abort_cnt_d;
    logic [63:0]      txd_q, txd_d;
    logic [7:0]       txc_q, txc_d;

    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [63:0]      sel_txd;
    logic [7:0]       sel_txc;
    logic             sel_eof;

    rr_pick #(
        .NPORT (NPORT)
    ) u_rr_pick (
        .req   (req),
        .last  (cur_port_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel_txd = src_txd[64*cur_port_q +: 64];
    assign sel_txc = src_txc[8*cur_port_q +: 8];
    assign sel_eof = src_eof[cur_port_q];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cur_port_d   = cur_port_q;
        word_cnt_d   = word_cnt_q;
        ifg_cnt_d    = ifg_cnt_q;
        abort_cnt_d  = abort_cnt_q;
        txd_d        = XGMII_IDLE_WORD;
        txc_d        = XGMII_CTRL_ALL;
        word_cnt_inc = word_cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StXfer;
                    gnt_d      = NPORT'(1) << pick_idx;
                    cur_port_d = pick_idx;
                    word_cnt_d = '0;
                end
            end
            StXfer: begin
                txd_d      = sel_txd;
                txc_d      = sel_txc;
                word_cnt_d = word_cnt_inc;
                if (sel_eof || (word_cnt_inc == WCW'(MAX_WORDS))) begin
                    state_d    = StIfg;
                    gnt_d      = '0;
                    word_cnt_d = '0;
                    ifg_cnt_d  = '0;
                    // eof wins: a frame ending exactly on the limit is a normal end.
                    if (!sel_eof) begin
                        txd_d = XGMII_ERROR_WORD;
                        txc_d = XGMII_CTRL_ALL;
                        if (abort_cnt_q != 16'hFFFF) begin
                            abort_cnt_d = abort_cnt_q + 16'd1;
                        end
                    end
                end
            end
            StIfg: begin
                if (ifg_cnt_q == ICW'(IFG_WORDS - 1)) begin
                    state_d = StIdle;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            cur_port_q  <= PW'(NPORT - 1);
            word_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
            abort_cnt_q <= '0;
            txd_q       <= XGMII_IDLE_WORD;
            txc_q       <= XGMII_CTRL_ALL;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cur_port_q  <= cur_port_d;
            word_cnt_q  <= word_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            abort_cnt_q <= abort_cnt_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
        end
    end

    assign gnt       = gnt_q;
    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign busy      = (state_q != StIdle);
    assign cur_port  = cur_port_q;
    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_arb.sv
// Randomised scoreboard bench for xgmii_tx_arb: frame-level source model feeds an
// expected-word queue that a negedge monitor drains against the shared XGMII lane.
module tb_xgmii_tx_arb;

    localparam int NP   = 4;
    localparam int IFG  = 2;
    localparam int MAXW = 4;
    localparam int NFR  = 128;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        last;
        logic        chk;
    } exp_t;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   gnt;
    logic [64*NP-1:0] src_txd = '0;
    logic [8*NP-1:0] src_txc = '0;
    logic [NP-1:0]   src_eof = '0;
    logic [63:0]     xgmii_txd;
    logic [7:0]      xgmii_txc;
    logic            busy;
    logic [1:0]      cur_port;
    logic [15:0]     abort_cnt;

    xgmii_tx_arb #(
        .NPORT     (NP),
        .IFG_WORDS (IFG),
        .MAX_WORDS (MAXW)
    ) dut (
        .xgmii_clk (clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .gnt       (gnt),
        .src_txd   (src_txd),
        .src_txc   (src_txc),
        .src_eof   (src_eof),
        .xgmii_txd (xgmii_txd),
        .xgmii_txc (xgmii_txc),
        .busy      (busy),
        .cur_port  (cur_port),
        .abort_cnt (abort_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source model: per-port list of frame lengths, consumed one word per granted cycle.
    int   len_tab [NP][NFR];
    int   head [NP];
    int   tail [NP];
    int   widx [NP];
    int   last_m = NP - 1;
    int   abort_m = 0;
    logic [NP-1:0] gnt_prev = '0;
    exp_t exp_q[$];
    exp_t pend;
    bit   pend_v = 1'b0;
    bit   exact_mode = 1'b0;
    int   frames_in_mode = 0;
    int   grant_log[$];
    int   s2_order [5] = '{0, 1, 2, 3, 0};
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rr_model(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (r[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit quiet();
        for (int i = 0; i < NP; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return (busy == 1'b0) && (exp_q.size() == 0);
    endfunction

    task automatic push_frame(input int p, input int len);
        len_tab[p][tail[p]] = len;
        tail[p]++;
        req[p] = 1'b1;
    endtask

    task automatic cycle();
        logic [NP-1:0] req_seen, g;
        logic [63:0]   d;
        logic [7:0]    c;
        exp_t          e;
        int            gp, len;
        req_seen = req;
        @(posedge clk);
        #1;
        g = gnt;
        if (pend_v) begin
            check("latency_txd", xgmii_txd, pend.d);
            check("latency_txc", 64'(xgmii_txc), 64'(pend.c));
            pend_v = 1'b0;
        end
        check("gnt_onehot", 64'($countones(g) <= 1), 64'd1);
        if (g != '0 && gnt_prev == '0) begin
            gp = rr_model(req_seen, last_m);
            check("grant_sel", 64'(g), (gp < 0) ? 64'd0 : (64'd1 << gp));
            check("busy_xfer", 64'(busy), 64'd1);
            if (gp >= 0) begin
                check("cur_port", 64'(cur_port), 64'(gp));
                last_m = gp;
            end
            for (int i = 0; i < NP; i++) if (g[i]) grant_log.push_back(i);
        end
        gnt_prev = g;
        for (int i = 0; i < NP; i++) begin
            if (g[i]) check("spurious_gnt", 64'(head[i] != tail[i]), 64'd1);
            if (g[i] && head[i] != tail[i]) begin
                d = {$urandom, $urandom};
                c = 8'($urandom_range(0, 127));
                widx[i]++;
                len = len_tab[i][head[i]];
                src_txd[64*i +: 64] = d;
                src_txc[8*i +: 8]   = c;
                src_eof[i]          = (widx[i] == len);
                e.chk = (widx[i] == 1) && exact_mode && (frames_in_mode > 0);
                if (widx[i] == 1) frames_in_mode++;
                if (widx[i] == len) begin
                    e.d = d; e.c = c; e.last = 1'b1;
                end else if (widx[i] == MAXW) begin
                    e.d = ERR_W; e.c = 8'hFF; e.last = 1'b1;
                    if (abort_m < 65535) abort_m++;
                end else begin
                    e.d = d; e.c = c; e.last = 1'b0;
                end
                if (e.last) begin
                    head[i]++;
                    widx[i] = 0;
                end
                exp_q.push_back(e);
                pend   = e;
                pend_v = 1'b1;
            end else begin
                src_txd[64*i +: 64] = {$urandom, $urandom};
                src_txc[8*i +: 8]   = 8'($urandom);
                src_eof[i]          = 1'($urandom_range(0, 1));
            end
            req[i] = (head[i] != tail[i]);
        end
    endtask

    task automatic wait_quiet(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            cycle();
            done = quiet();
        end
        check("timeout", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        req     = '0;
        for (int i = 0; i < NP; i++) begin
            head[i] = tail[i];
            widx[i] = 0;
        end
        repeat (2) cycle();
        sys_rst  = 1'b0;
        last_m   = NP - 1;
        abort_m  = 0;
        pend_v   = 1'b0;
        gnt_prev = '0;
    endtask

    // Monitor: pops one expected entry per non-idle output word and measures idle gaps.
    int   gap_cnt = 0;
    bit   armed = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (xgmii_txc === 8'hFF && xgmii_txd === IDLE_W) begin
                gap_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h/%h expected idle", xgmii_txd, xgmii_txc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_txd", xgmii_txd, mon_e.d);
                    check("out_txc", 64'(xgmii_txc), 64'(mon_e.c));
                    if (mon_e.chk) check("gap_exact", 64'(gap_cnt), 64'(IFG + 1));
                    else if (armed) check("gap_min", 64'(gap_cnt >= IFG + 1), 64'd1);
                    armed = mon_e.last;
                end
                gap_cnt = 0;
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_txd", xgmii_txd, IDLE_W);
        check("rst_txc", 64'(xgmii_txc), 64'hFF);
        check("rst_cur_port", 64'(cur_port), 64'(NP - 1));
        check("rst_abort", 64'(abort_cnt), 64'd0);

        // Single 3-word frame on port 0.
        push_frame(0, 3);
        cycle();
        check("s1_gnt", 64'(gnt), 64'd1);
        wait_quiet(200);
        repeat (2) cycle();
        check("s1_busy", 64'(busy), 64'd0);
        check("s1_idle_txd", xgmii_txd, IDLE_W);

        // All four sources requesting: round-robin order and exact gaps.
        do_reset();
        grant_log.delete();
        exact_mode     = 1'b1;
        frames_in_mode = 0;
        for (int p = 0; p < NP; p++) push_frame(p, 2);
        push_frame(0, 2);
        wait_quiet(400);
        exact_mode = 1'b0;
        check("s2_grants", 64'(grant_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            check($sformatf("s2_order%0d", k), 64'(grant_log[k]), 64'(s2_order[k]));
        end

        // Source never ends its frame: forced abort.
        do_reset();
        push_frame(0, 1000);
        wait_quiet(200);
        check("s3_abort", 64'(abort_cnt), 64'(abort_m));
        check("s3_gnt", 64'(gnt), 64'd0);

        // eof exactly on the word limit is a normal end.
        do_reset();
        push_frame(1, MAXW);
        wait_quiet(200);
        check("s4_abort", 64'(abort_cnt), 64'(abort_m));

        // Reset on the 2nd word of a frame.
        do_reset();
        push_frame(1, 5);
        for (int n = 0; n < 20 && widx[1] != 2; n++) cycle();
        check("s5_reached", 64'(widx[1]), 64'd2);
        sys_rst = 1'b1;
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        head[1] = tail[1];
        widx[1] = 0;
        pend_v  = 1'b0;
        cycle();
        check("s5_gnt", 64'(gnt), 64'd0);
        check("s5_txd", xgmii_txd, IDLE_W);
        check("s5_txc", 64'(xgmii_txc), 64'hFF);
        check("s5_cur_port", 64'(cur_port), 64'(NP - 1));
        check("s5_busy", 64'(busy), 64'd0);
        sys_rst  = 1'b0;
        last_m   = NP - 1;
        abort_m  = 0;
        gnt_prev = '0;
        grant_log.delete();
        push_frame(2, 3);
        wait_quiet(200);
        check("s5_regrant", 64'(grant_log.size() == 1 && grant_log[0] == 2), 64'd1);

        // Random traffic with mixed lengths, including over-long frames.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            push_frame($urandom_range(0, NP - 1), $urandom_range(1, 6));
            repeat ($urandom_range(0, 6)) cycle();
        end
        wait_quiet(3000);
        check("s6_abort", 64'(abort_cnt), 64'(abort_m));
        check("end_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_arb.md
XGMII_TX_ARB -- requirements
Module: xgmii_tx_arb

Parameters
REQ-001 The block SHALL have parameter NPORT, default 4, meaning the number of requesting sources (2..8).
REQ-002 The block SHALL have parameter IFG_WORDS, default 1, meaning the number of idle XGMII words inserted after every frame (>=1).
REQ-003 The block SHALL have parameter MAX_WORDS, default 1200, meaning the maximum words per grant before forced abort.

Interface
REQ-004 The block SHALL have port xgmii_clk, input, width 1: the single 156.25 MHz clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, width NPORT: per-source frame request.
REQ-007 The block SHALL have port gnt, output, width NPORT: per-source grant, registered, at most one bit high.
REQ-008 The block SHALL have port src_txd, input, width 64*NPORT: per-source XGMII data, with port i at [64i+63:64i].
REQ-009 The block SHALL have port src_txc, input, width 8*NPORT: per-source XGMII control, with port i at [8i+7:8i].
REQ-010 The block SHALL have port src_eof, input, width NPORT: marks the last word of a frame.
REQ-011 The block SHALL have port xgmii_txd, output, width 64: shared XGMII TX data, registered.
REQ-012 The block SHALL have port xgmii_txc, output, width 8: shared XGMII TX control, registered.
REQ-013 The block SHALL have port busy, output, width 1: high while in XFER or IFG.
REQ-014 The block SHALL have port cur_port, output, width clog2(NPORT): index of the last granted port.
REQ-015 The block SHALL have port abort_cnt, output, width 16: saturating count of forced aborts.

Function
REQ-016 The FSM SHALL have states IDLE, XFER and IFG.
REQ-017 In IDLE and IFG, xgmii_txd SHALL be 0x0707070707070707 and xgmii_txc SHALL be 0xFF.
REQ-018 In IDLE, if req is nonzero, the block SHALL pick the first set req bit searching round-robin from cur_port+1 (wrapping), set that gnt bit in the next cycle, load cur_port, and enter XFER.
REQ-019 In XFER, in every cycle gnt[i] is high the selected source SHALL present a valid word; there is no back-pressure.
REQ-020 That word SHALL appear on xgmii_txd/txc exactly 1 cycle later.
REQ-021 In XFER, req SHALL be ignored, and non-selected src_* inputs SHALL be ignored.
REQ-022 When src_eof[i] is high while gnt[i] is high, gnt SHALL drop the next cycle, the word counter SHALL clear, and the FSM SHALL enter IFG.
REQ-023 The word counter (width clog2(MAX_WORDS+1)) SHALL increment per granted word.
REQ-024 If the counter reaches MAX_WORDS with src_eof low, that word SHALL be replaced on the output by an error word (txd 0xFEFEFEFEFEFEFEFE, txc 0xFF).
REQ-025 On that forced abort, gnt SHALL drop the next cycle, abort_cnt SHALL increment (saturating at 0xFFFF), and the FSM SHALL enter IFG.
REQ-026 If src_eof and the MAX_WORDS condition coincide, the block SHALL treat it as a normal end: no error word, no abort count.
REQ-027 IFG SHALL last exactly IFG_WORDS cycles, then the FSM SHALL return to IDLE; arbitration occurs only in IDLE, so the minimum gap is IFG_WORDS+1 idle words.
REQ-028 The block SHALL not depend on a src_eof given on a source's first granted word; that is a legal 1-word frame.

Reset
REQ-029 When sys_rst is high at a clock edge, the FSM SHALL go to IDLE.
REQ-030 On reset, gnt SHALL be 0, xgmii_txd/txc SHALL be idle (0x07.., 0xFF), busy SHALL be 0, the word counter SHALL be 0, and abort_cnt SHALL be 0.
REQ-031 On reset, cur_port SHALL be NPORT-1, so that port 0 wins the first arbitration.
REQ-032 Reset mid-frame SHALL drop gnt the next cycle with no error word emitted; sources SHALL discard their partial frame.

Structure
REQ-033 Package xgmii_pkg SHALL hold the XGMII_IDLE (0x07) and XGMII_ERROR (0xFE) byte constants, the 64-bit idle/error word constants, and the FSM state enum.
REQ-034 The round-robin selection SHALL live in sub-module rr_pick (inputs req and last index; outputs found and the index), as pure combinational logic.
REQ-035 The FSM, counters and output registers SHALL live in xgmii_tx_arb.

Verification
REQ-036 Scenario 1: reset, then req=0001 with a 3-word frame -> gnt[0] asserted 1 cycle after req, the 3 words appear on the output with 1-cycle latency, then >=2 idle words and busy=0.
REQ-037 Scenario 2: req=1111 held, each source sends a 2-word frame -> grant order 0,1,2,3,0, and each frame is separated by exactly IFG_WORDS+1 idle words.
REQ-038 Scenario 3: MAX_WORDS=4, source never asserts eof -> output is 3 source words then 0xFE.. with txc=0xFF, gnt drops, abort_cnt=1.
REQ-039 Scenario 4: MAX_WORDS=4, eof on the 4th word -> normal frame, no error word, abort_cnt=0.
REQ-040 Scenario 5: sys_rst asserted on the 2nd word of a frame -> next cycle gnt=0, output idle, cur_port=NPORT-1; the next req on port 2 is granted normally.
